// File: rtl/s2p_word_if.sv
// s2p_word_if: bundle of the serial-input and parallel-output signals of
// the s2p_word deserialiser.
//   Serial side  : en, si, sync, clr_ovr   (driven by the front end)
//   Parallel side: po, po_valid, overrun, bit_cnt (driven by the deserialiser)
//                  po_ready                (driven by the consumer)
// modport slave  : the deserialiser's view.
// modport master : the view of whoever drives the deserialiser and consumes words.
interface s2p_word_if #(
    parameter int WIDTH = 8
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             en;
    logic             si;
    logic             sync;
    logic             clr_ovr;
    logic [WIDTH-1:0] po;
    logic             po_valid;
    logic             po_ready;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;

    modport slave (
        input  en, si, sync, clr_ovr, po_ready,
        output po, po_valid, overrun, bit_cnt
    );

    modport master (
        output en, si, sync, clr_ovr, po_ready,
        input  po, po_valid, overrun, bit_cnt
    );
endinterface

// File: rtl/s2p_word.sv
// s2p_word: parametrised serial-to-parallel deserialiser.
// Collects WIDTH serial bits (MSB-first or LSB-first) into a word, realigns on
// sync, and presents completed words on a registered valid/ready output. A word
// that completes while the output slot is still occupied is dropped and the
// sticky overrun flag is raised.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - s2p_word_if.slave: en/si/sync/clr_ovr/po_ready in,
//          po/po_valid/overrun/bit_cnt out (all registered)
module s2p_word #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    s2p_word_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_po;
    logic             r_po_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_sr_base;
    logic [WIDTH-1:0] w_sr_shift;
    logic             w_last;
    logic             w_complete;
    logic             w_slot_free;
    logic             w_load;
    logic             w_drop;

    // A sync restarts the word from an empty register, so the shift source is
    // zero on that edge; the sync bit (if any) becomes bit 0 of the new word.
    assign w_sr_base = bus.sync ? '0 : r_sr;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign w_sr_shift[gi] = bus.si;
                end else begin : g_mv
                    assign w_sr_shift[gi] = w_sr_base[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_in
                    assign w_sr_shift[gi] = bus.si;
                end else begin : g_mv
                    assign w_sr_shift[gi] = w_sr_base[gi+1];
                end
            end
        end
    endgenerate

    // After a sync the count restarts at 0/1, so the sync edge itself can never
    // complete a word.
    assign w_last      = (r_bit_cnt == CW'(WIDTH - 1));
    assign w_complete  = bus.en && !bus.sync && w_last;
    // Slot is free if empty or being emptied on this very edge.
    assign w_slot_free = !r_po_valid || bus.po_ready;
    assign w_load      = w_complete && w_slot_free;
    assign w_drop      = w_complete && !w_slot_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_po       <= '0;
            r_po_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (bus.sync || bus.en) begin
                r_sr <= bus.en ? w_sr_shift : '0;
            end

            if (bus.sync) begin
                r_bit_cnt <= bus.en ? CW'(1) : '0;
            end else if (bus.en) begin
                r_bit_cnt <= w_last ? '0 : r_bit_cnt + CW'(1);
            end

            if (w_load) begin
                r_po <= w_sr_shift;
            end

            if (w_load) begin
                r_po_valid <= 1'b1;
            end else if (bus.po_ready) begin
                r_po_valid <= 1'b0;
            end

            // Drop takes priority over the clear so no loss goes unreported.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.po       = r_po;
    assign bus.po_valid = r_po_valid;
    assign bus.overrun  = r_overrun;
    assign bus.bit_cnt  = r_bit_cnt;
endmodule

// File: tb/tb_s2p_word.sv
// tb_s2p_word: checks an MSB-first and an LSB-first WIDTH=4 s2p_word driven by
// identical stimulus against a queue-based reference model.
module tb_s2p_word;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, si, sync, clr_ovr, po_ready;

    s2p_word_if #(.WIDTH(W)) bus_m ();
    s2p_word_if #(.WIDTH(W)) bus_l ();

    assign bus_m.en = en;        assign bus_l.en = en;
    assign bus_m.si = si;        assign bus_l.si = si;
    assign bus_m.sync = sync;    assign bus_l.sync = sync;
    assign bus_m.clr_ovr = clr_ovr;   assign bus_l.clr_ovr = clr_ovr;
    assign bus_m.po_ready = po_ready; assign bus_l.po_ready = po_ready;

    s2p_word #(.WIDTH(W), .MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
    s2p_word #(.WIDTH(W), .MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    int checks = 0;
    int errors = 0;
    int words  = 0;

    // Reference model: bits received so far in arrival order, plus output slot.
    int         mq[$];
    logic [W-1:0] m_po_m, m_po_l;
    logic       m_valid, m_ovr;

    task automatic step(input logic a_rst, input logic a_en, input logic a_si,
                        input logic a_sync, input logic a_clr, input logic a_ready);
        logic complete;
        logic free;
        logic [W-1:0] wm, wl;
        rst = a_rst; en = a_en; si = a_si; sync = a_sync;
        clr_ovr = a_clr; po_ready = a_ready;
        @(posedge clk);
        complete = 1'b0; wm = '0; wl = '0;
        if (a_rst) begin
            mq.delete();
            m_po_m = '0; m_po_l = '0; m_valid = 1'b0; m_ovr = 1'b0;
        end else begin
            if (a_sync) begin
                mq.delete();
                if (a_en) mq.push_back(int'(a_si));
            end else if (a_en) begin
                mq.push_back(int'(a_si));
                if (mq.size() == W) begin
                    complete = 1'b1;
                    for (int k = 0; k < W; k++) begin
                        wm = wm | (W'(mq[k]) << (W - 1 - k));
                        wl = wl | (W'(mq[k]) << k);
                    end
                    mq.delete();
                end
            end
            free = !m_valid || a_ready;
            if (complete && free) begin
                m_po_m = wm; m_po_l = wl; m_valid = 1'b1;
            end else if (a_ready) begin
                m_valid = 1'b0;
            end
            if (complete && !free) m_ovr = 1'b1;
            else if (a_clr) m_ovr = 1'b0;
            if (complete) begin
                words++;
                $display("word %0d: msb=%b lsb=%b %s", words, wm, wl,
                         free ? "loaded" : "dropped");
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1, 1, 1, 0, 0, 0);
            checks++;
            if (bus_m.po !== 4'b0000 || bus_m.po_valid !== 1'b0 ||
                bus_m.overrun !== 1'b0 || bus_m.bit_cnt !== 2'd0) begin
                errors++;
                $display("FAIL reset_m: po=%b v=%b ovr=%b cnt=%0d, want all 0",
                         bus_m.po, bus_m.po_valid, bus_m.overrun, bus_m.bit_cnt);
            end
            checks++;
            if (bus_l.po !== 4'b0000 || bus_l.po_valid !== 1'b0 ||
                bus_l.overrun !== 1'b0 || bus_l.bit_cnt !== 2'd0) begin
                errors++;
                $display("FAIL reset_l: po=%b v=%b ovr=%b cnt=%0d, want all 0",
                         bus_l.po, bus_l.po_valid, bus_l.overrun, bus_l.bit_cnt);
            end
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_bit_order();
        logic [3:0] pat;
        pat = 4'b1011;
        for (int k = 3; k >= 0; k--) begin
            step(0, 1, pat[k], 0, 0, 1);
            checks++;
            if (bus_m.bit_cnt !== 2'(mq.size())) begin
                errors++;
                $display("FAIL order_cnt: got %0d want %0d", bus_m.bit_cnt, mq.size());
            end
        end
        checks++;
        if (bus_m.po !== 4'b1011 || bus_m.po_valid !== 1'b1) begin
            errors++;
            $display("FAIL msb_word: po=%b v=%b want 1011 v=1", bus_m.po, bus_m.po_valid);
        end
        checks++;
        if (bus_l.po !== 4'b1101 || bus_l.po_valid !== 1'b1) begin
            errors++;
            $display("FAIL lsb_word: po=%b v=%b want 1101 v=1", bus_l.po, bus_l.po_valid);
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (bus_m.po_valid !== 1'b0 || bus_l.po_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_drop_valid: m=%b l=%b want 0", bus_m.po_valid, bus_l.po_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] pat;
        pat = 8'b1100_0101;
        for (int k = 7; k >= 0; k--) begin
            step(0, 1, pat[k], 0, 0, 0);
            if (k == 4) begin
                checks++;
                if (bus_m.po !== 4'b1100 || bus_m.po_valid !== 1'b1 || bus_m.overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_first: po=%b v=%b ovr=%b want 1100 1 0",
                             bus_m.po, bus_m.po_valid, bus_m.overrun);
                end
            end
        end
        checks++;
        if (bus_m.po !== 4'b1100 || bus_m.po_valid !== 1'b1 || bus_m.overrun !== 1'b1 ||
            bus_l.po !== 4'b0011 || bus_l.overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_drop: po_m=%b v=%b ovr=%b po_l=%b ovr_l=%b want 1100 1 1 0011 1",
                     bus_m.po, bus_m.po_valid, bus_m.overrun, bus_l.po, bus_l.overrun);
        end
        step(0, 0, 0, 0, 1, 0);
        checks++;
        if (bus_m.overrun !== 1'b0 || bus_m.po !== 4'b1100 || bus_m.po_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_clear: ovr=%b po=%b v=%b want 0 1100 1",
                     bus_m.overrun, bus_m.po, bus_m.po_valid);
        end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_sync();
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 0, 1, 0, 1);
        checks++;
        if (bus_m.bit_cnt !== 2'd1 || bus_m.po_valid !== 1'b0) begin
            errors++;
            $display("FAIL sync_cnt: cnt=%0d v=%b want 1 0", bus_m.bit_cnt, bus_m.po_valid);
        end
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        checks++;
        if (bus_m.po_valid !== 1'b0) begin
            errors++;
            $display("FAIL sync_early: v=%b want 0", bus_m.po_valid);
        end
        step(0, 1, 0, 0, 0, 1);
        checks++;
        if (bus_m.po !== 4'b0110 || bus_m.po_valid !== 1'b1 || bus_l.po !== 4'b0110) begin
            errors++;
            $display("FAIL sync_word: po_m=%b v=%b po_l=%b want 0110 1 0110",
                     bus_m.po, bus_m.po_valid, bus_l.po);
        end
    endtask

    task automatic test_gapped();
        int w0;
        w0 = words;
        for (int c = 0; c < 16; c++) begin
            step(0, (c % 2) == 0, 1'($urandom_range(0, 1)), 0, 0, 1);
            checks++;
            if (bus_m.bit_cnt !== 2'(mq.size()) || bus_m.po_valid !== m_valid ||
                bus_m.po !== m_po_m || bus_m.overrun !== 1'b0) begin
                errors++;
                $display("FAIL gapped c%0d: cnt=%0d v=%b po=%b ovr=%b want %0d %b %b 0", c,
                         bus_m.bit_cnt, bus_m.po_valid, bus_m.po, bus_m.overrun,
                         mq.size(), m_valid, m_po_m);
            end
        end
        checks++;
        if (words - w0 != 2) begin
            errors++;
            $display("FAIL gapped_words: got %0d want 2", words - w0);
        end
    endtask

    task automatic test_back_to_back();
        int vcount;
        vcount = 0;
        for (int c = 0; c < 12; c++) begin
            step(0, 1, 1'($urandom_range(0, 1)), 0, 0, 1);
            if (bus_m.po_valid === 1'b1) vcount++;
            checks++;
            if (bus_m.po_valid !== m_valid || bus_m.po !== m_po_m ||
                bus_l.po !== m_po_l || bus_m.overrun !== 1'b0) begin
                errors++;
                $display("FAIL b2b c%0d: v=%b po_m=%b po_l=%b ovr=%b want %b %b %b 0", c,
                         bus_m.po_valid, bus_m.po, bus_l.po, bus_m.overrun,
                         m_valid, m_po_m, m_po_l);
            end
        end
        checks++;
        if (vcount != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d valid cycles want 3", vcount);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
            checks++;
            if (bus_m.po !== m_po_m || bus_m.po_valid !== m_valid ||
                bus_m.overrun !== m_ovr || bus_m.bit_cnt !== 2'(mq.size()) ||
                bus_l.po !== m_po_l || bus_l.po_valid !== m_valid ||
                bus_l.overrun !== m_ovr || bus_l.bit_cnt !== 2'(mq.size())) begin
                errors++;
                $display("FAIL random c%0d: m=%b/%b/%b/%0d l=%b/%b/%b/%0d want m=%b l=%b v=%b ovr=%b cnt=%0d",
                         c, bus_m.po, bus_m.po_valid, bus_m.overrun, bus_m.bit_cnt,
                         bus_l.po, bus_l.po_valid, bus_l.overrun, bus_l.bit_cnt,
                         m_po_m, m_po_l, m_valid, m_ovr, mq.size());
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; si = 1'b0; sync = 1'b0; clr_ovr = 1'b0; po_ready = 1'b0;
        m_po_m = '0; m_po_l = '0; m_valid = 1'b0; m_ovr = 1'b0;
        test_reset();
        test_bit_order();
        test_backpressure();
        test_sync();
        test_gapped();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
